// File: rtl/ghash_pkg.sv
// rtl/ghash_pkg.sv - shared constants, FSM states and length-block packing for the GHASH tag checker
package ghash_pkg;

    localparam int BLOCK_W = 128;
    localparam int DIGIT_W = 8;
    localparam int LEN_W   = 64;
    // Counters count blocks; <<7 turns them into bit lengths that must fit in LEN_W.
    localparam int CNT_W   = LEN_W - 7;

    localparam logic [BLOCK_W-1:0] R_POLY = {8'he1, 120'd0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_MULT,
        ST_LEN,
        ST_TAG
    } state_t;

    function automatic int n_steps(input int nb_data, input int nb_digit);
        return nb_data / nb_digit;
    endfunction

    function automatic logic [2*LEN_W-1:0] pack_len_block(input logic [CNT_W-1:0] aad_cnt,
                                                          input logic [CNT_W-1:0] ct_cnt);
        return {aad_cnt, 7'b0, ct_cnt, 7'b0};
    endfunction

endpackage

// File: rtl/ghash_tag_checker_if.sv
// rtl/ghash_tag_checker_if.sv - message/verdict bundle; i_tag_nbytes exists only with GHASH_TAG_TRUNC_EN
interface ghash_tag_checker_if #(parameter int NB_DATA = 128);

    logic               i_start;
    logic [NB_DATA-1:0] i_hash_key;
    logic [NB_DATA-1:0] i_ek_y0;
    logic [NB_DATA-1:0] i_tag;
    logic [NB_DATA-1:0] i_data;
    logic               i_valid;
    logic               i_aad;
    logic               i_finish;
    logic               o_ready;
    logic               o_done;
    logic               o_tag_ok;
    logic [NB_DATA-1:0] o_tag;
`ifdef GHASH_TAG_TRUNC_EN
    logic [4:0]         i_tag_nbytes;

    modport master (output i_start, i_hash_key, i_ek_y0, i_tag, i_data, i_valid, i_aad,
                    i_finish, i_tag_nbytes,
                    input  o_ready, o_done, o_tag_ok, o_tag);
    modport slave  (input  i_start, i_hash_key, i_ek_y0, i_tag, i_data, i_valid, i_aad,
                    i_finish, i_tag_nbytes,
                    output o_ready, o_done, o_tag_ok, o_tag);
`else
    modport master (output i_start, i_hash_key, i_ek_y0, i_tag, i_data, i_valid, i_aad,
                    i_finish,
                    input  o_ready, o_done, o_tag_ok, o_tag);
    modport slave  (input  i_start, i_hash_key, i_ek_y0, i_tag, i_data, i_valid, i_aad,
                    i_finish,
                    output o_ready, o_done, o_tag_ok, o_tag);
`endif

endinterface

// File: rtl/gf_2to128_digit_mult.sv
// rtl/gf_2to128_digit_mult.sv - iterative GF(2^128) multiplier, NB_DIGIT operand bits per cycle, GCM bit order
module gf_2to128_digit_mult
    import ghash_pkg::*;
#(
    parameter int NB_DATA  = BLOCK_W,
    parameter int NB_DIGIT = DIGIT_W
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_z
);

    localparam int N  = NB_DATA / NB_DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [NB_DATA-1:0] a_q;
    logic [NB_DATA-1:0] v_q;
    logic [NB_DATA-1:0] z_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic [NB_DATA-1:0] z_n;
    logic [NB_DATA-1:0] v_n;
    logic               last;

    // a_q is shifted left every cycle so its MSB always holds the next operand bit.
    always_comb begin
        z_n = z_q;
        v_n = v_q;
        for (int i = 0; i < NB_DIGIT; i++) begin
            if (a_q[NB_DATA-1-i]) begin
                z_n = z_n ^ v_n;
            end
            v_n = v_n[0] ? ((v_n >> 1) ^ R_POLY) : (v_n >> 1);
        end
    end

    assign last   = busy_q && (cnt_q == CW'(N - 1));
    assign o_busy = busy_q;
    assign o_done = last;
    assign o_z    = z_n;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            a_q    <= '0;
            v_q    <= '0;
            z_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (i_start) begin
            a_q    <= i_a;
            v_q    <= i_b;
            z_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            a_q   <= a_q << NB_DIGIT;
            v_q   <= v_n;
            z_q   <= z_n;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ghash_tag_checker.sv
// rtl/ghash_tag_checker.sv - GCM receive GHASH + tag compare; GHASH_TAG_TRUNC_EN enables truncated-tag compare
module ghash_tag_checker
    import ghash_pkg::*;
#(
    parameter int NB_DATA  = BLOCK_W,
    parameter int NB_DIGIT = DIGIT_W,
    parameter int NB_LEN   = LEN_W
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    ghash_tag_checker_if.slave bus
);

    localparam int CW = NB_LEN - 7;

    state_t             state;
    logic [NB_DATA-1:0] x_q;
    logic [NB_DATA-1:0] h_q;
    logic [NB_DATA-1:0] ek_q;
    logic [NB_DATA-1:0] tag_q;
    logic [CW-1:0]      aad_cnt;
    logic [CW-1:0]      ct_cnt;
    logic               seq_err;
    logic               done_q;
    logic               tag_ok_q;
    logic [NB_DATA-1:0] tag_out_q;

    logic               accept_blk;
    logic               accept_fin;
    logic               mult_start;
    logic [NB_DATA-1:0] mult_a;
    logic               mult_busy;
    logic               mult_done;
    logic               mult_fin;
    logic [NB_DATA-1:0] mult_z;
    logic [NB_DATA-1:0] tag_calc;
    logic               tag_match;

    // A block with finish in the same cycle wins; the finish must be re-presented.
    assign accept_blk = (state == ST_ACC) && bus.i_valid && !bus.i_start;
    assign accept_fin = (state == ST_ACC) && bus.i_finish && !bus.i_valid && !bus.i_start;
    assign mult_start = accept_blk || accept_fin;
    assign mult_a     = accept_blk ? (x_q ^ bus.i_data)
                                   : (x_q ^ pack_len_block(aad_cnt, ct_cnt));
    assign mult_fin   = mult_done && mult_busy;
    assign tag_calc   = mult_z ^ ek_q;

    gf_2to128_digit_mult #(
        .NB_DATA  (NB_DATA),
        .NB_DIGIT (NB_DIGIT)
    ) u_mult (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_start   (mult_start),
        .i_a       (mult_a),
        .i_b       (h_q),
        .o_busy    (mult_busy),
        .o_done    (mult_done),
        .o_z       (mult_z)
    );

`ifdef GHASH_TAG_TRUNC_EN
    logic [4:0]         nbytes_q;
    logic [7:0]         shamt;
    logic [NB_DATA-1:0] mask;
    logic               range_ok;

    // Keep only the nbytes most-significant bytes of the tag.
    assign shamt     = 8'(NB_DATA) - {nbytes_q, 3'b000};
    assign mask      = {NB_DATA{1'b1}} << shamt;
    assign range_ok  = (nbytes_q >= 5'd12) && (nbytes_q <= 5'd16);
    assign tag_match = range_ok && ((tag_calc & mask) == (tag_q & mask));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            nbytes_q <= '0;
        end else if (bus.i_start) begin
            nbytes_q <= bus.i_tag_nbytes;
        end
    end
`else
    assign tag_match = (tag_calc == tag_q);
`endif

    assign bus.o_ready  = (state == ST_ACC);
    assign bus.o_done   = done_q;
    assign bus.o_tag_ok = tag_ok_q;
    assign bus.o_tag    = tag_out_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            x_q       <= '0;
            h_q       <= '0;
            ek_q      <= '0;
            tag_q     <= '0;
            aad_cnt   <= '0;
            ct_cnt    <= '0;
            seq_err   <= 1'b0;
            done_q    <= 1'b0;
            tag_ok_q  <= 1'b0;
            tag_out_q <= '0;
        end else if (bus.i_start) begin
            state     <= ST_ACC;
            x_q       <= '0;
            h_q       <= bus.i_hash_key;
            ek_q      <= bus.i_ek_y0;
            tag_q     <= bus.i_tag;
            aad_cnt   <= '0;
            ct_cnt    <= '0;
            seq_err   <= 1'b0;
            done_q    <= 1'b0;
            tag_ok_q  <= 1'b0;
            tag_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_ACC: begin
                    if (accept_blk) begin
                        state <= ST_MULT;
                        if (bus.i_aad) begin
                            if (aad_cnt != {CW{1'b1}}) aad_cnt <= aad_cnt + 1'b1;
                            if (ct_cnt != '0) seq_err <= 1'b1;
                        end else begin
                            if (ct_cnt != {CW{1'b1}}) ct_cnt <= ct_cnt + 1'b1;
                        end
                    end else if (accept_fin) begin
                        state <= ST_LEN;
                    end
                end
                ST_MULT: begin
                    if (mult_fin) begin
                        x_q   <= mult_z;
                        state <= ST_ACC;
                    end
                end
                ST_LEN: begin
                    if (mult_fin) begin
                        x_q       <= mult_z;
                        tag_out_q <= tag_calc;
                        tag_ok_q  <= tag_match & ~seq_err;
                        done_q    <= 1'b1;
                        state     <= ST_TAG;
                    end
                end
                ST_TAG:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
